modinv_unit: RTL and testbench

Parametrised binary extended-Euclid modular inverse/division engine. It computes a⁻¹ mod p, or b·a⁻¹ mod p in division mode, for any odd modulus of WIDTH bits. It flags non-invertible operands and bad moduli instead of hanging. It sits in the ALU as a multi-cycle functional unit behind a start/busy/done handshake and supersedes the fixed 32-bit inverse engine.

---
 rtl/modinv_unit.sv | 189 ++++++++++++++++++
 tb/tb_modinv_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/modinv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : modinv_unit
//  Description : Binary extended-Euclid modular inverse / division engine.
//                Computes a^-1 mod p (mode 0) or b*a^-1 mod p (mode 1) for an
//                odd WIDTH-bit modulus. Bad moduli and non-invertible operands
//                are reported through err. The unit has a start/busy/done
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module modinv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] result_o,
    output logic             err_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam logic [WIDTH-1:0] c_ZERO  = '0;
    localparam logic [WIDTH-1:0] c_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_THREE = WIDTH'(3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;

    // Euclid pair and their Bezout-style companions (x1 tracks u, x2 tracks v)
    logic [WIDTH-1:0] u_q, v_q;
    logic [WIDTH-1:0] x1_q, x2_q;
    logic [WIDTH-1:0] p_q;

    logic [WIDTH-1:0] u_d, v_d;
    logic [WIDTH-1:0] x1_d, x2_d;

    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic             done_q;
    logic             busy_q;

    logic             pre_err;

    // Halve x modulo m (m odd): an odd x is made even by adding m first.
    // The sum needs one extra bit, the halved value always fits in WIDTH.
    function automatic logic [WIDTH-1:0] half_mod(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] s;
        s = {1'b0, x} + (x[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return WIDTH'(s >> 1);
    endfunction

    // Modular subtraction for x, y in [0, m). The wrapped WIDTH-bit result of
    // x - y + m is exact because the true value is below m.
    function automatic logic [WIDTH-1:0] sub_mod(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] m
    );
        return (x >= y) ? (x - y) : (x - y + m);
    endfunction

    // Operand sanity check, evaluated on the live inputs at acceptance
    always_comb begin
        pre_err = 1'b0;
        if (!p_i[0])                      pre_err = 1'b1;
        if (p_i < c_THREE)                pre_err = 1'b1;
        if (a_i == c_ZERO)                pre_err = 1'b1;
        if (a_i >= p_i)                   pre_err = 1'b1;
        if (mode_i && (b_i >= p_i))       pre_err = 1'b1;
    end

    // One reduction step of the binary Euclid loop; termination tests live in the FSM
    always_comb begin
        u_d  = u_q;
        v_d  = v_q;
        x1_d = x1_q;
        x2_d = x2_q;
        if (!u_q[0]) begin
            u_d  = u_q >> 1;
            x1_d = half_mod(x1_q, p_q);
        end else if (!v_q[0]) begin
            v_d  = v_q >> 1;
            x2_d = half_mod(x2_q, p_q);
        end else if (u_q >= v_q) begin
            u_d  = u_q - v_q;
            x1_d = sub_mod(x1_q, x2_q, p_q);
        end else begin
            v_d  = v_q - u_q;
            x2_d = sub_mod(x2_q, x1_q, p_q);
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            p_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        busy_q <= 1'b1;
                        p_q    <= p_i;
                        if (pre_err) begin
                            // Rejected operands skip the loop entirely
                            result_q <= '0;
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            u_q     <= a_i;
                            v_q     <= p_i;
                            x1_q    <= mode_i ? b_i : c_ONE;
                            x2_q    <= '0;
                            state_q <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (u_q == c_ONE) begin
                        result_q <= x1_q;
                        err_q    <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (v_q == c_ONE) begin
                        result_q <= x2_q;
                        err_q    <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (u_q == c_ZERO) begin
                        // u collapsed to zero: v holds gcd(a, p) > 1
                        result_q <= '0;
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        u_q  <= u_d;
                        v_q  <= v_d;
                        x1_q <= x1_d;
                        x2_q <= x2_d;
                    end
                end

                S_DONE: begin
                    // busy stays high here so a start in this cycle is ignored
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign err_o    = err_q;
    assign done_o   = done_q;
    assign busy_o   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_modinv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modinv_unit
//  Description : Self-checking bench for modinv_unit (WIDTH 32 and WIDTH 8
//                instances) against a division-based extended-Euclid model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modinv_unit;

    localparam int c_LAT32 = 4*32 + 2;
    localparam int c_LAT8  = 4*8 + 2;

    logic        clk;
    logic        rst_n;

    logic        start32, mode32, err32, done32, busy32;
    logic [31:0] a32, b32, p32, result32;

    logic        start8, mode8, err8, done8, busy8;
    logic [7:0]  a8, b8, p8, result8;

    int n_checks;
    int n_errors;

    modinv_unit #(.WIDTH(32)) u_dut32 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start32),
        .mode_i   (mode32),
        .a_i      (a32),
        .b_i      (b32),
        .p_i      (p32),
        .result_o (result32),
        .err_o    (err32),
        .done_o   (done32),
        .busy_o   (busy32)
    );

    modinv_unit #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start8),
        .mode_i   (mode8),
        .a_i      (a8),
        .b_i      (b8),
        .p_i      (p8),
        .result_o (result8),
        .err_o    (err8),
        .done_o   (done8),
        .busy_o   (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: classic quotient-based extended Euclid on 64-bit integers
    function automatic void ref_model(input bit mode, input longint unsigned a,
                                      input longint unsigned b, input longint unsigned p,
                                      output longint unsigned res, output bit err);
        longint r0, r1, t0, t1, q, tmp;
        longint unsigned inv;
        res = 0;
        err = 1'b1;
        if ((p % 2) == 0 || p < 3 || a == 0 || a >= p || (mode && b >= p)) return;
        r0 = longint'(p); r1 = longint'(a); t0 = 0; t1 = 1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q*r1; r0 = r1; r1 = tmp;
            tmp = t0 - q*t1; t0 = t1; t1 = tmp;
        end
        if (r0 != 1) return;
        inv = longint'(t0 < 0 ? t0 + longint'(p) : t0);
        res = mode ? (b * inv) % p : inv;
        err = 1'b0;
    endfunction

    task automatic drive(input bit w8, input bit st, input bit mode,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        if (w8) begin
            start8 = st; mode8 = mode; a8 = a[7:0]; b8 = b[7:0]; p8 = p[7:0];
        end else begin
            start32 = st; mode32 = mode; a32 = a; b32 = b; p32 = p;
        end
    endtask

    function automatic logic get_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction

    function automatic logic get_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction

    // Issue one operation and wait (bounded) for its done pulse.
    // lat = edges after the accepting edge until done is visible.
    task automatic run_op(input bit w8, input bit mode, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] p, input bit pulse,
                          output logic [31:0] res, output logic err, output int lat,
                          output bit busy_ok);
        int limit;
        limit = (w8 ? c_LAT8 : c_LAT32) + 8;
        @(negedge clk);
        drive(w8, 1'b1, mode, a, b, p);
        @(posedge clk); #1;
        lat = 0;
        busy_ok = 1'b1;
        if (!pulse) drive(w8, 1'b0, mode, a, b, p);
        while (!get_done(w8) && lat < limit) begin
            if (!get_busy(w8)) busy_ok = 1'b0;
            // Keep requesting with other operands; all must be ignored
            if (pulse) drive(w8, 1'b1, ~mode, $urandom, $urandom, $urandom | 1);
            @(posedge clk); #1;
            lat++;
        end
        drive(w8, 1'b0, mode, a, b, p);
        check_value("done_seen", {63'd0, get_done(w8)}, 64'd1);
        check_value("busy_at_done", {63'd0, get_busy(w8)}, 64'd1);
        res = w8 ? {24'd0, result8} : result32;
        err = w8 ? err8 : err32;
        @(posedge clk); #1;
        check_value("done_one_cycle", {63'd0, get_done(w8)}, 64'd0);
        check_value("busy_after_done", {63'd0, get_busy(w8)}, 64'd0);
    endtask

    task automatic run_and_check(input string tag, input bit w8, input bit mode,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
        logic [31:0]     res;
        logic            err;
        int              lat;
        bit              bok;
        longint unsigned eres;
        bit              eerr;
        run_op(w8, mode, a, b, p, 1'b0, res, err, lat, bok);
        ref_model(mode, longint'(a), longint'(b), longint'(p), eres, eerr);
        check_value({tag, "_result"}, {32'd0, res}, eres);
        check_value({tag, "_err"}, {63'd0, err}, {63'd0, eerr});
        check_value({tag, "_lat_bound"}, {63'd0, lat <= (w8 ? c_LAT8 : c_LAT32)}, 64'd1);
    endtask

    initial begin
        logic [31:0]     res, ra, rb, rp;
        logic            err;
        int              lat, cnt;
        bit              bok, rmode;
        longint unsigned prod;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_outputs32", {result32, 29'd0, err32, done32, busy32}, 64'd0);
        check_value("reset_outputs8",  {56'd0, result8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases at WIDTH 32
        run_op(1'b0, 1'b0, 3, 0, 13, 1'b0, res, err, lat, bok);
        check_value("inv3_13", {32'd0, res}, 64'd9);
        check_value("inv3_13_err", {63'd0, err}, 64'd0);
        check_value("inv3_13_busy", {63'd0, bok}, 64'd1);

        run_op(1'b0, 1'b1, 3, 5, 13, 1'b0, res, err, lat, bok);
        check_value("div5_3_13", {32'd0, res}, 64'd6);
        check_value("div5_3_13_err", {63'd0, err}, 64'd0);

        run_op(1'b0, 1'b0, 1, 0, 13, 1'b0, res, err, lat, bok);
        check_value("inv1_13", {32'd0, res}, 64'd1);
        check_value("inv1_13_lat", lat, 64'd1);

        run_op(1'b0, 1'b0, 6, 0, 9, 1'b0, res, err, lat, bok);
        check_value("gcd3_result", {32'd0, res}, 64'd0);
        check_value("gcd3_err", {63'd0, err}, 64'd1);
        check_value("gcd3_via_run", {63'd0, lat > 0}, 64'd1);

        run_op(1'b0, 1'b0, 3, 0, 10, 1'b0, res, err, lat, bok);
        check_value("even_p_err", {63'd0, err}, 64'd1);
        check_value("even_p_lat", lat, 64'd0);

        run_op(1'b0, 1'b0, 13, 0, 13, 1'b0, res, err, lat, bok);
        check_value("a_eq_p_err", {63'd0, err}, 64'd1);
        check_value("a_eq_p_result", {32'd0, res}, 64'd0);

        run_op(1'b0, 1'b1, 3, 13, 13, 1'b0, res, err, lat, bok);
        check_value("b_eq_p_err", {63'd0, err}, 64'd1);

        // Directed cases at WIDTH 8
        run_op(1'b1, 1'b0, 2, 0, 251, 1'b0, res, err, lat, bok);
        check_value("w8_inv2", {32'd0, res}, 64'd126);
        check_value("w8_inv2_lat", {63'd0, lat <= c_LAT8}, 64'd1);
        run_op(1'b1, 1'b0, 250, 0, 251, 1'b0, res, err, lat, bok);
        check_value("w8_inv250", {32'd0, res}, 64'd250);
        check_value("w8_inv250_lat", {63'd0, lat <= c_LAT8}, 64'd1);

        // Start held high every cycle during a long run
        run_op(1'b0, 1'b0, 32'h7FFF_FFFF, 0, 32'hFFFF_FFFB, 1'b1, res, err, lat, bok);
        prod = (longint'(res) * 64'h7FFF_FFFF) % 64'hFFFF_FFFB;
        check_value("pulse_inverse", prod, 64'd1);
        check_value("pulse_err", {63'd0, err}, 64'd0);
        check_value("pulse_busy", {63'd0, bok}, 64'd1);
        cnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done32) cnt++;
        end
        check_value("pulse_single_done", cnt, 64'd0);

        // Reset in the middle of a run
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF, 0, 32'hFFFF_FFFB);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 0, 32'hFFFF_FFFB);
        repeat (5) @(posedge clk);
        #1;
        check_value("busy_before_reset", {63'd0, busy32}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_value("midrun_reset_outputs", {result32, 29'd0, err32, done32, busy32}, 64'd0);
        cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done32) cnt++;
        end
        check_value("no_done_in_reset", cnt, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 1'b0, 3, 0, 13, 1'b0, res, err, lat, bok);
        check_value("after_reset_inv3", {32'd0, res}, 64'd9);

        // Random regression, WIDTH 32
        for (int i = 0; i < 40; i++) begin
            rp = (i % 2 == 1) ? ($urandom | 32'd1) : ($urandom_range(3, 200) | 32'd1);
            ra = (i % 5 == 0) ? $urandom : ($urandom % rp);
            rb = (i % 7 == 0) ? $urandom : ($urandom % rp);
            rmode = 1'($urandom_range(0, 1));
            run_and_check("rnd32", 1'b0, rmode, ra, rb, rp);
        end

        // Random regression, WIDTH 8 (covers a >= p, b >= p, even p)
        for (int i = 0; i < 40; i++) begin
            rp = (i % 9 == 0) ? $urandom_range(0, 255) : ($urandom_range(3, 255) | 32'd1);
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            rmode = 1'($urandom_range(0, 1));
            run_and_check("rnd8", 1'b1, rmode, ra, rb, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
